stepper_regs: RTL
=================

STEPPER_REGS -- requirements
Module: stepper_regs

Interface
REQ-001 SHALL have port system1000  in  1  system clock; all state on its rising edge.
REQ-002 SHALL have port system1000_rstn  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port i_adr_match  in  1  I2C slave address-matched level; high from address ACK until next START.
REQ-004 SHALL have port i_rw  in  1  R/W bit of matched address; 1 = master read, 0 = master write.
REQ-005 SHALL have port i_dat_vld  in  1  one-cycle pulse; a byte transfer finished.
REQ-006 SHALL have port i_dat  in  8  last received byte; stable when i_dat_vld is high.
REQ-007 SHALL have port i_busy  in  1  motor-core busy flag.
REQ-008 SHALL have port i_step_pos  in  16  motor-core step position.
REQ-009 SHALL have port o_tx_dat  out  8  byte presented to the I2C slave for master reads.
REQ-010 SHALL have port o_motor_en  out  1  CTRL[0].
REQ-011 SHALL have port o_dir  out  1  CTRL[1].
REQ-012 SHALL have port o_step_period  out  16  clocks per step.
REQ-013 SHALL have port o_step_target  out  16  target step count.
REQ-014 SHALL have port o_go  out  1  one-cycle move-start pulse.

Function
REQ-015 SHALL decode the register map: 0 CTRL (RW), 1 PERIOD_L, 2 PERIOD_H, 3 TARGET_L, 4 TARGET_H, 5 STATUS (RO, bit0 = i_busy, other bits 0), 6 POS_L (RO), 7 POS_H (RO).
REQ-016 SHALL implement FSM IDLE, PTR, WDATA, READ, entered from the registered i_adr_match rising edge: i_rw=0 -> PTR, i_rw=1 -> READ.
REQ-017 SHALL, in PTR on i_dat_vld, load the 3-bit pointer from i_dat[2:0], ignore i_dat[7:3], and enter WDATA.
REQ-018 SHALL, in WDATA on i_dat_vld, write i_dat to register[pointer], then increment the pointer modulo 8 (7 wraps to 0).
REQ-019 SHALL ignore writes to addresses 5-7, while still incrementing the pointer.
REQ-020 SHALL, in READ, register o_tx_dat = register[pointer] every cycle, and increment the pointer modulo 8 on each i_dat_vld.
REQ-021 SHALL return to IDLE within one cycle of i_adr_match falling, from any state, keeping the pointer value.
REQ-022 SHALL, on a CTRL write with i_dat[7]=1, assert o_go for exactly one cycle, one cycle after i_dat_vld; CTRL[7] SHALL read 0.
REQ-023 SHALL ignore i_dat_vld while in IDLE.
REQ-024 SHALL take the i_adr_match edge as higher priority when it coincides with i_dat_vld (repeated START).

Reset
REQ-025 SHALL, on reset, set: FSM = IDLE; pointer = 0; CTRL = 0x00; o_step_period = 16'd1000; o_step_target = 0; o_tx_dat = 0x00; o_go = 0.
REQ-026 SHALL, when reset is asserted mid-transaction, abort it immediately without committing any partial 16-bit value.

Configuration
REQ-027 SHALL, with STEPPER_REGS_ATOMIC_EN defined, apply 16-bit atomicity:
- a write to a _L register goes to a shadow byte;
- the 16-bit output updates only on the write to the matching _H register, taking {i_dat, shadow};
- a read of POS_L snapshots i_step_pos[15:8] for the subsequent read of POS_H.
REQ-028 SHALL, without STEPPER_REGS_ATOMIC_EN, apply each byte write directly to its output half, and read POS_H live from i_step_pos.

Structure
REQ-029 SHALL place the register address constants, reset values, CTRL bit positions and the FSM state enum in package stepper_regs_pkg.
REQ-030 SHALL be a single module; no sub-module is natural.

Verification
REQ-031 SHALL cover: write transaction, bytes 0x01, 0x34, 0x12 -> o_step_period = 0x1234 (atomic build: updates only after the 0x12 byte).
REQ-032 SHALL cover: write bytes 0x00, 0x83 -> o_motor_en=1, o_dir=1, o_go high exactly 1 cycle; a later CTRL read returns 0x03.
REQ-033 SHALL cover: pointer 0x07, then write 0xAA, 0x05 -> POS_H unchanged, CTRL = 0x05 (wrap-around).
REQ-034 SHALL cover: i_step_pos = 0x5678, write pointer 0x06, restart as read, two bytes; i_step_pos changes to 0x9900 between the two bytes -> o_tx_dat 0x78 then 0x56 (atomic build).
REQ-035 SHALL cover: reset asserted after PERIOD_L write -> o_step_period = 1000, FSM = IDLE, pointer = 0.
REQ-036 SHALL cover: i_busy=1, read from pointer 5 -> o_tx_dat = 0x01.

Source files
------------

// File: rtl/stepper_regs_pkg.sv
// Shared constants for the stepper I2C register block: register map,
// reset values, CTRL bit positions and the transaction FSM states.
package stepper_regs_pkg;

    localparam logic [2:0] ADR_CTRL     = 3'd0;
    localparam logic [2:0] ADR_PERIOD_L = 3'd1;
    localparam logic [2:0] ADR_PERIOD_H = 3'd2;
    localparam logic [2:0] ADR_TARGET_L = 3'd3;
    localparam logic [2:0] ADR_TARGET_H = 3'd4;
    localparam logic [2:0] ADR_STATUS   = 3'd5;
    localparam logic [2:0] ADR_POS_L    = 3'd6;
    localparam logic [2:0] ADR_POS_H    = 3'd7;

    localparam logic [7:0]  CTRL_RST   = 8'h00;
    localparam logic [15:0] PERIOD_RST = 16'd1000;
    localparam logic [15:0] TARGET_RST = 16'd0;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_DIR_BIT = 1;
    localparam int CTRL_GO_BIT  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PTR,
        ST_WDATA,
        ST_READ
    } state_t;

endpackage

// File: rtl/stepper_regs.sv
// I2C-slave register file for the stepper motor core (pointer byte, then data bytes).
// Define STEPPER_REGS_ATOMIC_EN for shadowed 16-bit writes and a latched POS_H read.
module stepper_regs
    import stepper_regs_pkg::*;
(
    input  logic        system1000,
    input  logic        system1000_rstn,
    input  logic        i_adr_match,
    input  logic        i_rw,
    input  logic        i_dat_vld,
    input  logic [7:0]  i_dat,
    input  logic        i_busy,
    input  logic [15:0] i_step_pos,
    output logic [7:0]  o_tx_dat,
    output logic        o_motor_en,
    output logic        o_dir,
    output logic [15:0] o_step_period,
    output logic [15:0] o_step_target,
    output logic        o_go
);

    state_t      state, state_nxt;
    logic        adr_match_p1;
    logic        adr_rise;
    logic [2:0]  ptr;
    logic        ptr_load, ptr_inc, wr_en;
    logic [6:0]  ctrl;
    logic [7:0]  rd_dat;
    logic [7:0]  pos_h;

`ifdef STEPPER_REGS_ATOMIC_EN
    logic [7:0]  period_sh, target_sh, pos_snap;
`endif

    assign adr_rise      = i_adr_match & ~adr_match_p1;
    assign o_motor_en    = ctrl[CTRL_EN_BIT];
    assign o_dir         = ctrl[CTRL_DIR_BIT];

    // A fresh address match wins over a coincident byte strobe.
    always_comb begin
        state_nxt = state;
        ptr_load  = 1'b0;
        ptr_inc   = 1'b0;
        wr_en     = 1'b0;
        if (!i_adr_match) begin
            state_nxt = ST_IDLE;
        end else if (adr_rise) begin
            state_nxt = i_rw ? ST_READ : ST_PTR;
        end else begin
            case (state)
                ST_PTR: if (i_dat_vld) begin
                    ptr_load  = 1'b1;
                    state_nxt = ST_WDATA;
                end
                ST_WDATA: if (i_dat_vld) begin
                    wr_en   = 1'b1;
                    ptr_inc = 1'b1;
                end
                ST_READ: if (i_dat_vld) ptr_inc = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef STEPPER_REGS_ATOMIC_EN
    assign pos_h = pos_snap;
`else
    assign pos_h = i_step_pos[15:8];
`endif

    always_comb begin
        rd_dat = 8'h00;
        case (ptr)
            ADR_CTRL:     rd_dat = {1'b0, ctrl};
            ADR_PERIOD_L: rd_dat = o_step_period[7:0];
            ADR_PERIOD_H: rd_dat = o_step_period[15:8];
            ADR_TARGET_L: rd_dat = o_step_target[7:0];
            ADR_TARGET_H: rd_dat = o_step_target[15:8];
            ADR_STATUS:   rd_dat = {7'd0, i_busy};
            ADR_POS_L:    rd_dat = i_step_pos[7:0];
            ADR_POS_H:    rd_dat = pos_h;
            default:      rd_dat = 8'h00;
        endcase
    end

    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state        <= ST_IDLE;
            adr_match_p1 <= 1'b0;
            ptr          <= 3'd0;
            o_tx_dat     <= 8'h00;
            o_go         <= 1'b0;
        end else begin
            state        <= state_nxt;
            adr_match_p1 <= i_adr_match;
            o_go         <= wr_en && (ptr == ADR_CTRL) && i_dat[CTRL_GO_BIT];
            if (ptr_load) begin
                ptr <= i_dat[2:0];
            end else if (ptr_inc) begin
                ptr <= ptr + 3'd1;
            end
            if (state == ST_READ) begin
                o_tx_dat <= rd_dat;
            end
        end
    end

    // GO is a strobe, so CTRL keeps only bits 6:0 and bit 7 reads back as 0.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            ctrl          <= CTRL_RST[6:0];
            o_step_period <= PERIOD_RST;
            o_step_target <= TARGET_RST;
`ifdef STEPPER_REGS_ATOMIC_EN
            period_sh     <= 8'h00;
            target_sh     <= 8'h00;
`endif
        end else if (wr_en) begin
            case (ptr)
                ADR_CTRL:     ctrl <= i_dat[6:0];
`ifdef STEPPER_REGS_ATOMIC_EN
                ADR_PERIOD_L: period_sh     <= i_dat;
                ADR_PERIOD_H: o_step_period <= {i_dat, period_sh};
                ADR_TARGET_L: target_sh     <= i_dat;
                ADR_TARGET_H: o_step_target <= {i_dat, target_sh};
`else
                ADR_PERIOD_L: o_step_period[7:0]  <= i_dat;
                ADR_PERIOD_H: o_step_period[15:8] <= i_dat;
                ADR_TARGET_L: o_step_target[7:0]  <= i_dat;
                ADR_TARGET_H: o_step_target[15:8] <= i_dat;
`endif
                default: ;
            endcase
        end
    end

`ifdef STEPPER_REGS_ATOMIC_EN
    // Latch the high position byte while POS_L is being presented.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            pos_snap <= 8'h00;
        end else if (state == ST_READ && ptr == ADR_POS_L) begin
            pos_snap <= i_step_pos[15:8];
        end
    end
`endif

endmodule
